// File: rtl/jk_bank_writer.sv
// Masked write controller for a bank of JK flip-flop cells: drive, read back, retry.
// Optional build macro TOGGLE_MODE_EN selects toggle excitation instead of set/clear.
module jk_bank_writer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             wr_ack,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data_r, mask_r, data_nx, mask_nx;
  logic [WIDTH-1:0] j_nx, k_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ack_nx, busy_nx, done_nx, err_nx;

  logic [WIDTH-1:0] src_data, src_mask;
  logic [WIDTH-1:0] set_c, clr_c;
  logic             match_c;

  // New requests excite from the live inputs; retries excite from the latched target.
  assign src_data = (state == IDLE) ? wr_data : data_r;
  assign src_mask = (state == IDLE) ? wr_mask : mask_r;

`ifdef TOGGLE_MODE_EN
  // Toggle only the masked bits that currently differ from the target.
  assign set_c = (q_fb ^ src_data) & src_mask;
  assign clr_c = (q_fb ^ src_data) & src_mask;
`else
  assign set_c = src_data & src_mask;
  assign clr_c = ~src_data & src_mask;
`endif

  assign match_c = (q_fb & mask_r) == (data_r & mask_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data_r <= '0;
      mask_r <= '0;
      cnt    <= '0;
      j      <= '0;
      k      <= '0;
      wr_ack <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      data_r <= data_nx;
      mask_r <= mask_nx;
      cnt    <= cnt_nx;
      j      <= j_nx;
      k      <= k_nx;
      wr_ack <= ack_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      err    <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = data_r;
    mask_nx  = mask_r;
    cnt_nx   = cnt;
    j_nx     = '0;
    k_nx     = '0;
    ack_nx   = 1'b0;
    busy_nx  = busy;
    done_nx  = 1'b0;
    err_nx   = 1'b0;

    unique case (state)
      IDLE: begin
        if (wr_req) begin
          data_nx  = wr_data;
          mask_nx  = wr_mask;
          cnt_nx   = '0;
          j_nx     = set_c;
          k_nx     = clr_c;
          ack_nx   = 1'b1;
          busy_nx  = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        state_nx = CHECK;
      end
      CHECK: begin
        if (match_c) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt < CNT_W'(MAX_RETRY)) begin
          cnt_nx   = cnt + CNT_W'(1);
          j_nx     = set_c;
          k_nx     = clr_c;
          state_nx = DRIVE;
        end else begin
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        busy_nx  = 1'b0;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_bank_writer.sv
// Directed bench for jk_bank_writer with a behavioural JK bank and a stuck-at-0 injector.
`timescale 1ns/1ps
module tb_jk_bank_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req;
  logic [7:0] wr_data, wr_mask, q_fb, j, k;
  logic       wr_ack, busy, done, err;

  logic [7:0] bank;
  logic [7:0] stuck0;
  logic       bank_load;
  logic [7:0] bank_load_val;

  int tests_run = 0;
  int tests_failed = 0;

  jk_bank_writer #(.WIDTH(8), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_mask(wr_mask),
    .q_fb(q_fb), .j(j), .k(k), .wr_ack(wr_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural JK cells: 00 hold, 10 set, 01 clear, 11 toggle.
  always @(posedge clk) begin
    if (bank_load) bank <= bank_load_val;
    else begin
      for (int b = 0; b < 8; b++) begin
        case ({j[b], k[b]})
          2'b10:   bank[b] <= 1'b1;
          2'b01:   bank[b] <= 1'b0;
          2'b11:   bank[b] <= ~bank[b];
          default: bank[b] <= bank[b];
        endcase
      end
    end
  end

  assign q_fb = bank & ~stuck0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v);
    bank_load = 1'b1;
    bank_load_val = v;
    tick();
    bank_load = 1'b0;
  endtask

  // Single uninterrupted write; expected J/K are hand-computed by the caller.
  task automatic do_write(input string tag, input logic [7:0] d, input logic [7:0] m,
                          input logic [7:0] ej, input logic [7:0] ek, input logic [7:0] ebank);
    wr_req = 1'b1; wr_data = d; wr_mask = m;
    tick();
    check({tag, " e0 ack"}, 32'(wr_ack), 1);
    check({tag, " e0 busy"}, 32'(busy), 1);
    check({tag, " e0 j"}, 32'(j), 32'(ej));
    check({tag, " e0 k"}, 32'(k), 32'(ek));
    wr_req = 1'b0;
    tick();
    check({tag, " e1 jk"}, 32'({j, k}), 0);
    check({tag, " e1 ack"}, 32'(wr_ack), 0);
    check({tag, " e1 busy"}, 32'(busy), 1);
    tick();
    check({tag, " e2 done"}, 32'(done), 1);
    check({tag, " e2 err"}, 32'(err), 0);
    check({tag, " e2 busy"}, 32'(busy), 0);
    check({tag, " bank"}, 32'(bank), 32'(ebank));
    tick();
    check({tag, " e3 done"}, 32'(done), 0);
  endtask

  initial begin
    int drives, dones, err_edge;
    reset = 1'b1; wr_req = 1'b0; wr_data = '0; wr_mask = '0;
    stuck0 = '0; bank_load = 1'b1; bank_load_val = '0;
    tick(); tick();
    check("reset outs", 32'({j, k, wr_ack, busy, done, err}), 0);
    reset = 1'b0; bank_load = 1'b0;
    tick();
    check("idle outs", 32'({j, k, wr_ack, busy, done, err}), 0);

    preload(8'h00);
`ifdef TOGGLE_MODE_EN
    do_write("basic", 8'hA5, 8'hFF, 8'hA5, 8'hA5, 8'hA5);
`else
    do_write("basic", 8'hA5, 8'hFF, 8'hA5, 8'h5A, 8'hA5);
`endif

    preload(8'hFF);
`ifdef TOGGLE_MODE_EN
    do_write("masked", 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'hF0);
`else
    do_write("masked", 8'h00, 8'h0F, 8'h00, 8'h0F, 8'hF0);
`endif

    preload(8'h3C);
    do_write("mask0", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C);

    preload(8'h3C);
`ifdef TOGGLE_MODE_EN
    do_write("toggle", 8'h0F, 8'hFF, 8'h33, 8'h33, 8'h0F);
`else
    do_write("setclr", 8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h0F);
`endif

    // Stuck-at-0 bit 3: three drive attempts then err at edge 6.
    preload(8'h00);
    stuck0 = 8'h08;
    drives = 0; dones = 0; err_edge = -1;
    wr_req = 1'b1; wr_data = 8'h08; wr_mask = 8'h08;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 0) begin
        check("stuck ack", 32'(wr_ack), 1);
        wr_req = 1'b0;
      end
      if (j != 8'h00) begin
        drives++;
        check("stuck j", 32'(j), 32'h08);
      end
      if (done) dones++;
      if (err && err_edge < 0) err_edge = e;
    end
    check("stuck drives", 32'(drives), 3);
    check("stuck dones", 32'(dones), 0);
    check("stuck err edge", 32'(err_edge), 6);
    check("stuck busy after", 32'(busy), 0);
    check("stuck err cleared", 32'(err), 0);
    stuck0 = 8'h00;

    // Second request held while busy; accepted on the edge after done.
    preload(8'h00);
    wr_req = 1'b1; wr_data = 8'h11; wr_mask = 8'hFF;
    tick();
    check("bb e0 ack", 32'(wr_ack), 1);
    wr_data = 8'h22; wr_mask = 8'hF0;
    tick();
    check("bb e1 ack", 32'(wr_ack), 0);
    tick();
    check("bb e2 ack", 32'(wr_ack), 0);
    check("bb e2 done", 32'(done), 1);
    check("bb first bank", 32'(bank), 32'h11);
    tick();
    check("bb e3 ack", 32'(wr_ack), 1);
    check("bb e3 done", 32'(done), 0);
`ifdef TOGGLE_MODE_EN
    check("bb e3 jk", 32'({j, k}), 32'h3030);
`else
    check("bb e3 jk", 32'({j, k}), 32'h20D0);
`endif
    wr_req = 1'b0;
    tick();
    check("bb e4 done", 32'(done), 0);
    tick();
    check("bb e5 done", 32'(done), 1);
    check("bb second bank", 32'(bank), 32'h21);
    tick();

    // Reset during DRIVE aborts without done/err.
    preload(8'h00);
    wr_req = 1'b1; wr_data = 8'hFF; wr_mask = 8'hFF;
    tick();
    check("rst e0 ack", 32'(wr_ack), 1);
    check("rst e0 j", 32'(j), 32'hFF);
    reset = 1'b1; wr_req = 1'b0;
    tick();
    check("rst e1 outs", 32'({j, k, wr_ack, busy, done, err}), 0);
    reset = 1'b0;
    tick();
    check("rst e2 done/err", 32'({done, err}), 0);
    preload(8'h00);
`ifdef TOGGLE_MODE_EN
    do_write("post-rst", 8'h5A, 8'hFF, 8'h5A, 8'h5A, 8'h5A);
`else
    do_write("post-rst", 8'h5A, 8'hFF, 8'h5A, 8'hA5, 8'h5A);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
